fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Front-end controller for the out-of-order core. It owns the program counter and drives the combinational instruction-memory read port.
- Fetched words are buffered in a small in-order queue. The queue is handed to decode/issue over a valid/ready handshake.
- Handles downstream back-pressure, redirects (branch resolution/flush) and halt (hlt, primary opcode 6'h3F).
- Sits between instruction memory and the instruction decoder/issue logic.

Parameters:
- PC_W, 32: program-counter width; PC is a word index, incremented by 1 per fetch.
- IM_AW, 10: instruction-memory address width; im_addr = pc[IM_AW-1:0].
- DEPTH, 4: fetch-buffer entries; power of two, >= 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: reset, asynchronous, active-high.
- im_addr, output, IM_AW: instruction-memory read address.
- im_data, input, 32: instruction word at im_addr; combinational, same cycle.
- out_valid, output, 1: buffer head holds a valid instruction.
- out_ready, input, 1: consumer accepts the head this cycle.
- out_inst, output, 32: head instruction word; 0 when empty.
- out_pc, output, PC_W: PC of the head instruction; 0 when empty.
- redirect_valid, input, 1: flush and restart fetch.
- redirect_pc, input, PC_W: new fetch PC.
- halted, output, 1: hlt has been fetched; fetching has stopped.
- fetch_count, output, 3-bit ($clog2(DEPTH)+1 at DEPTH=4): current buffer occupancy.

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, buffer empty (head=tail=count=0), out_valid=0, out_inst=0, out_pc=0, halted=0.
- States:
  - FETCH: fetching; the only state that enqueues.
  - HALTED: no enqueue, halted=1.
- Enqueue condition: state==FETCH && !redirect_valid && (count<DEPTH || (out_valid && out_ready)).
  - On enqueue, write {im_data, pc} at tail and set pc <= pc+1.
  - PC wraps modulo 2^PC_W; im_addr wraps modulo 2^IM_AW.
- Full buffer with no dequeue: PC holds and im_addr stays stable. This is a stall; no word is lost or duplicated.
- Dequeue occurs when out_valid && out_ready. The head advances on the same edge.
- Simultaneous enqueue and dequeue at count==DEPTH: count stays DEPTH.
- Simultaneous enqueue and dequeue at count==0: not possible, since out_valid=0.
- Buffer is show-ahead. out_inst/out_pc come from the head entry's registers, not from im_data.
- Latency: an instruction fetched at edge N is visible on out_* after edge N; first out_valid one cycle after reset release.
- Halt: when an enqueued word has im_data[31:26]==6'h3F:
  - it is enqueued normally;
  - state <= HALTED and halted <= 1 on that edge;
  - pc <= pc+1 still applies.
  - Instructions already buffered continue to drain.
- Redirect (highest priority, edge with redirect_valid=1):
  - buffer cleared (count=0, head=tail=0);
  - pc <= redirect_pc;
  - state <= FETCH, halted <= 0;
  - any enqueue or dequeue that cycle is suppressed; out_ready is ignored.
  - The first word from redirect_pc is enqueued on the following edge.
- Back-to-back redirects: the last one wins. Fetch resumes one cycle after the last redirect.
- In HALTED, only redirect or rst leave the state.
- Asynchronous reset mid-operation discards all buffer contents immediately.
- Pointer arithmetic is modulo DEPTH. count is a separate register, updated as +1, -1 or 0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - adds outputs perf_fetched[31:0] and perf_stall[31:0], both reset to 0, both wrapping at 2^32;
  - perf_fetched increments on every enqueue;
  - perf_stall increments on cycles with state==FETCH && count==DEPTH && !(out_valid&&out_ready) && !redirect_valid.
  - Redirect does not clear either counter.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Memory {0:32'h2001007B, 1:32'h10200003, 2:32'hAC010000}, out_ready=1 -> out_pc 0,1,2 on consecutive cycles after reset; out_inst matches; no bubbles.
- out_ready=0 for 10 cycles -> count reaches 4 and holds; im_addr holds at 4; perf_stall=6 with FETCH_PERF_EN. Then out_ready=1 -> out_pc 0..7 in order, none missing or duplicated.
- Word 5=32'hFC000000, out_ready=1 -> halted rises on the edge that fetches pc 5; out_pc 5 delivered last; no further out_valid.
- At count=3 pulse redirect_valid with redirect_pc=20 and out_ready=1 -> next cycle out_valid=0, count=0; following cycle out_pc=20.
- While HALTED, redirect_pc=2 -> halted=0 and fetching resumes at pc 2, 3, ...
- Assert rst mid-stream at count=2 -> out_valid, halted and count go to 0 immediately without a clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch front-end: owns the PC, reads instruction memory combinationally and queues
// {inst, pc} pairs in a show-ahead FIFO. Optional perf counters under FETCH_PERF_EN.
module fetch_sequencer #(
   parameter int unsigned     PC_W     = 32,
   parameter int unsigned     IM_AW    = 10,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [IM_AW-1:0]        im_addr,
   input  logic [31:0]             im_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_inst,
   output logic [PC_W-1:0]         out_pc,
   input  logic                    redirect_valid,
   input  logic [PC_W-1:0]         redirect_pc,
   output logic                    halted,
   output logic [$clog2(DEPTH):0]  fetch_count
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]             perf_fetched,
   output logic [31:0]             perf_stall
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {FETCH, HALTED} state_t;

   typedef struct packed {
      logic [31:0]     inst;
      logic [PC_W-1:0] pc;
   } entry_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q;
   logic [PTR_W-1:0]   head_q, tail_q;
   logic [CNT_W-1:0]   count_q;
   entry_t             buf_q [DEPTH];
   logic               full, enq, deq, is_hlt;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign is_hlt    = (im_data[31:26] == 6'h3F);
   // Redirect wins over everything, so it masks both queue operations.
   assign deq = out_valid && out_ready && !redirect_valid;
   assign enq = (state_q == FETCH) && !redirect_valid && (!full || (out_valid && out_ready));

   assign im_addr     = pc_q[IM_AW-1:0];
   assign out_inst    = out_valid ? buf_q[head_q].inst : '0;
   assign out_pc      = out_valid ? buf_q[head_q].pc   : '0;
   assign halted      = (state_q == HALTED);
   assign fetch_count = count_q;

   always_comb begin
      state_d = state_q;
      if (redirect_valid)
         state_d = FETCH;
      else if (enq && is_hlt)
         state_d = HALTED;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (redirect_valid) begin
            pc_q    <= redirect_pc;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (enq) begin
               pc_q   <= pc_q + PC_W'(1);
               tail_q <= tail_q + PTR_W'(1);
            end
            if (deq)
               head_q <= head_q + PTR_W'(1);
            case ({enq, deq})
               2'b10:   count_q <= count_q + CNT_W'(1);
               2'b01:   count_q <= count_q - CNT_W'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // Payload storage needs no reset: out_* are gated by occupancy.
   always_ff @(posedge clk) begin
      if (enq)
         buf_q[tail_q] <= '{inst: im_data, pc: pc_q};
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (enq)
            perf_fetched <= perf_fetched + 32'd1;
         if ((state_q == FETCH) && full && !(out_valid && out_ready) && !redirect_valid)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
